// File: rtl/typing_session_sequencer.sv
// Typing-test session sequencer: countdown, timed run, sequential WPM divide,
// double-dabble BCD conversion of the results and a rotating result display.
module typing_session_sequencer #(
  parameter int COUNTDOWN_S = 3,
  parameter int MAX_S       = 5999,
  parameter int PAGE_S      = 2,
  parameter int SAT         = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic        start,
  input  logic        abort,
  input  logic        word_done,
  input  logic        key_miss,
  input  logic [13:0] target_words,
  output logic [2:0]  phase,
  output logic        run_active,
  output logic [3:0]  countdown,
  output logic [13:0] elapsed_s,
  output logic [13:0] words_done,
  output logic [13:0] missed,
  output logic        result_valid,
  output logic [1:0]  page,
  output logic [15:0] disp_bcd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNTDN = 3'd1,
    S_RUN   = 3'd2,
    S_DIV   = 3'd3,
    S_BCD   = 3'd4,
    S_SHOW  = 3'd5
  } state_t;

  localparam logic [13:0] SAT_V = 14'(SAT);
  localparam logic [13:0] MAX_V = 14'(MAX_S);
  localparam logic [3:0]  CD_V  = 4'(COUNTDOWN_S);
  localparam logic [7:0]  PG_V  = 8'(PAGE_S - 1);

  state_t      state_q, state_d;
  logic [13:0] target_q, countdown_q_w, elapsed_q, words_q, missed_q, wpm_q;
  logic [3:0]  countdown_q;
  logic [1:0]  page_q;
  logic [7:0]  page_cnt_q;
  logic [19:0] div_num_q;
  logic [13:0] div_rem_q, div_den_q;
  logic [4:0]  div_cnt_q;
  logic [13:0] bcd_bin_q;
  logic [15:0] bcd_acc_q;
  logic [3:0]  bcd_iter_q;
  logic [1:0]  bcd_idx_q;
  logic [15:0] res_wpm_q, res_missed_q, res_elapsed_q;

  logic        start_ok, run_done, div_last, div_fit, bcd_last_iter, bcd_done;
  logic [13:0] words_nxt, elapsed_nxt, missed_nxt, div_rem_nxt, wpm_nxt;
  logic [14:0] div_trial;
  logic [19:0] quotient;
  logic [15:0] bcd_adj, bcd_shift;

  function automatic logic [13:0] sat_inc(input logic [13:0] v, input logic en);
    return (en && v < SAT_V) ? v + 14'd1 : v;
  endfunction

  assign countdown_q_w = {10'd0, countdown_q};

  // Shared datapath terms: saturating counter updates, divider step, BCD step.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    start_ok    = start && (target_words != 14'd0);
    words_nxt   = sat_inc(words_q, word_done);
    elapsed_nxt = sat_inc(elapsed_q, sec_tick);
    missed_nxt  = sat_inc(missed_q, key_miss);
    run_done    = (words_nxt >= target_q) || (elapsed_nxt >= MAX_V);

    div_trial   = {div_rem_q, div_num_q[19]};
    div_fit     = div_trial >= {1'b0, div_den_q};
    div_rem_nxt = div_fit ? 14'(div_trial - {1'b0, div_den_q}) : div_trial[13:0];
    quotient    = {div_num_q[18:0], div_fit};
    wpm_nxt     = (quotient > 20'(SAT_V)) ? SAT_V : quotient[13:0];
    div_last    = div_cnt_q == 5'd19;

    bcd_adj = bcd_acc_q;
    for (int d = 0; d < 4; d++) begin
      if (bcd_acc_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_acc_q[4*d +: 4] + 4'd3;
    end
    bcd_shift     = 16'({bcd_adj, bcd_bin_q[13]});
    bcd_last_iter = bcd_iter_q == 4'd13;
    bcd_done      = bcd_last_iter && (bcd_idx_q == 2'd2);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_SHOW: if (start_ok) state_d = S_CNTDN;
        S_CNTDN:        if (sec_tick && countdown_q == 4'd1) state_d = S_RUN;
        S_RUN:          if (run_done) state_d = S_DIV;
        S_DIV:          if (div_last) state_d = S_BCD;
        S_BCD:          if (bcd_done) state_d = S_SHOW;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Session datapath: counters, divider, converter, result registers, paging.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: result registers are reset along with everything else so abort and reset match exactly.
    if (rst || abort) begin
      target_q <= '0; countdown_q <= '0; elapsed_q <= '0; words_q <= '0;
      missed_q <= '0; wpm_q <= '0; page_q <= '0; page_cnt_q <= '0;
      div_num_q <= '0; div_rem_q <= '0; div_den_q <= '0; div_cnt_q <= '0;
      bcd_bin_q <= '0; bcd_acc_q <= '0; bcd_iter_q <= '0; bcd_idx_q <= '0;
      res_wpm_q <= '0; res_missed_q <= '0; res_elapsed_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_SHOW: begin
          if (start_ok) begin
            target_q    <= (target_words > SAT_V) ? SAT_V : target_words;
            countdown_q <= CD_V;
            elapsed_q   <= '0;
            words_q     <= '0;
            missed_q    <= '0;
            page_q      <= '0;
            page_cnt_q  <= '0;
          end else if (state_q == S_SHOW && sec_tick) begin
            if (page_cnt_q == PG_V) begin
              page_cnt_q <= '0;
              page_q     <= (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
            end else begin
              page_cnt_q <= page_cnt_q + 8'd1;
            end
          end
        end
        S_CNTDN: if (sec_tick) countdown_q <= countdown_q - 4'd1;
        S_RUN: begin
          elapsed_q <= elapsed_nxt;
          words_q   <= words_nxt;
          missed_q  <= missed_nxt;
          if (run_done) begin
            div_num_q <= 20'(words_nxt) * 20'd60;
            div_den_q <= (elapsed_nxt == 14'd0) ? 14'd1 : elapsed_nxt;
            div_rem_q <= '0;
            div_cnt_q <= '0;
          end
        end
        S_DIV: begin
          div_num_q <= quotient;
          div_rem_q <= div_rem_nxt;
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_last) begin
            wpm_q      <= wpm_nxt;
            bcd_bin_q  <= wpm_nxt;
            bcd_acc_q  <= '0;
            bcd_iter_q <= '0;
            bcd_idx_q  <= '0;
          end
        end
        S_BCD: begin
          if (bcd_last_iter) begin
            unique case (bcd_idx_q)
              2'd0:    res_wpm_q     <= bcd_shift;
              2'd1:    res_missed_q  <= bcd_shift;
              default: res_elapsed_q <= bcd_shift;
            endcase
            bcd_bin_q  <= (bcd_idx_q == 2'd0) ? missed_q : elapsed_q;
            bcd_acc_q  <= '0;
            bcd_iter_q <= '0;
            bcd_idx_q  <= bcd_idx_q + 2'd1;
            page_q     <= '0;
            page_cnt_q <= '0;
          end else begin
            bcd_acc_q  <= bcd_shift;
            bcd_bin_q  <= {bcd_bin_q[12:0], 1'b0};
            bcd_iter_q <= bcd_iter_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display mux: the selected result page, blank outside SHOW.
  always_comb begin
    disp_bcd = '0;
    if (state_q == S_SHOW) begin
      unique case (page_q)
        2'd0:    disp_bcd = res_wpm_q;
        2'd1:    disp_bcd = res_missed_q;
        default: disp_bcd = res_elapsed_q;
      endcase
    end
  end

  assign phase        = state_q;
  assign run_active   = state_q == S_RUN;
  assign result_valid = state_q == S_SHOW;
  assign countdown    = countdown_q_w[3:0];
  assign elapsed_s    = elapsed_q;
  assign words_done   = words_q;
  assign missed       = missed_q;
  assign page         = page_q;

  logic unused_wpm;
  assign unused_wpm = ^{wpm_q, countdown_q_w[13:4]};

endmodule
